// File: rtl/ws2812_pkg.sv
// Shared types, widths and helpers for the WS2812 frame sequencer.
package ws2812_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam int GRB_W                = 24;
  localparam int DEFAULT_RESET_CYCLES = 2800;

  // (ch * (b + 1)) >> 8 keeps b = 255 an exact identity and b = 0 fully dark.
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, ch} * ({9'd0, b} + 17'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// NUM_LEDS x 24 pixel store: one write port, one synchronous read port, read-before-write.
// Writes at or beyond NUM_LEDS are dropped so narrow index bits can never alias a live pixel.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [GRB_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [GRB_W-1:0]  rd_data
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [GRB_W-1:0] mem_q [NUM_LEDS];
  logic [GRB_W-1:0] rd_data_q;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en && (int'(wr_addr) < NUM_LEDS);
  assign rd_ok = int'(rd_addr) < NUM_LEDS;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
    rd_data_q <= rd_ok ? mem_q[rd_addr[IDX_W-1:0]] : '0;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: pixel RAM -> valid/ready GRB stream -> latch gap -> frame_done.
// First word 2 cycles after start, 2-cycle turnaround, grb held until grb_ready.
// WS2812_BRIGHTNESS_EN adds a brightness input applied per channel as each word is fetched.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 8,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic [23:0]       grb,
  output logic              grb_valid,
  input  logic              grb_ready,
  input  logic              tx_idle,
  output logic              line_hold
);

  localparam int                CNT_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [GRB_W-1:0]  grb_q, grb_d;
  logic              grb_valid_q, grb_valid_d;
  logic              busy_q, busy_d;
  logic [GRB_W-1:0]  rd_data;
  logic [GRB_W-1:0]  fetch_word;
  logic              hold;
  logic              done;

  // Read address follows idx_d so the word is already at the RAM output during FETCH.
  ws2812_pixel_ram #(
    .NUM_LEDS (NUM_LEDS),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

`ifdef WS2812_BRIGHTNESS_EN
  assign fetch_word = {scale_ch(rd_data[23:16], brightness),
                       scale_ch(rd_data[15:8],  brightness),
                       scale_ch(rd_data[7:0],   brightness)};
`else
  assign fetch_word = rd_data;
`endif

  // The gap must start in the very cycle the encoder reports idle, so hold/done look at tx_idle directly.
  assign hold = (state_q == LATCH) && (armed_q || tx_idle);
  assign done = hold && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    grb_d       = grb_q;
    grb_valid_d = grb_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      FETCH: begin
        state_d     = SEND;
        grb_d       = fetch_word;
        grb_valid_d = 1'b1;
      end
      SEND: begin
        if (grb_ready) begin
          grb_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = LATCH;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        if (hold) begin
          armed_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (done) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            armed_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      grb_q       <= '0;
      grb_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      grb_q       <= grb_d;
      grb_valid_q <= grb_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign grb        = grb_q;
  assign grb_valid  = grb_valid_q;
  assign busy       = busy_q;
  assign line_hold  = hold;
  assign frame_done = done;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: table-driven frames, hand-written corner cases, random frames.
module tb_ws2812_frame_ctrl;

  localparam int N  = 3;
  localparam int AW = 3;
  localparam int RC = 2800;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          start;
  logic          busy;
  logic          frame_done;
  logic [23:0]   grb;
  logic          grb_valid;
  logic          grb_ready;
  logic          tx_idle;
  logic          line_hold;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]    brightness;
`endif

  always #10 clk = ~clk;

  ws2812_frame_ctrl #(
    .NUM_LEDS     (N),
    .ADDR_W       (AW),
    .RESET_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .busy       (busy),
    .frame_done (frame_done),
    .grb        (grb),
    .grb_valid  (grb_valid),
    .grb_ready  (grb_ready),
    .tx_idle    (tx_idle),
    .line_hold  (line_hold)
  );

  typedef struct {
    string       name;
    logic [23:0] w0, w1, w2;
    int          stall_idx, stall_len, idle_wait;
    bit          mid_start, pre_started, chain_next;
    logic [23:0] e0, e1, e2;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          bri_now = 255;
  logic [23:0] model_mem [$];
  logic [23:0] last_word0;
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    if (a < N) model_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Reference: what the encoder should receive for pixel k under the current brightness.
  function automatic logic [23:0] exp_word(input int k);
    logic [23:0] r;
    r = model_mem[k];
`ifdef WS2812_BRIGHTNESS_EN
    for (int c = 0; c < 3; c++) begin
      int ch;
      ch = int'(model_mem[k][c*8 +: 8]);
      r[c*8 +: 8] = 8'((ch * (bri_now + 1)) / 256);
    end
`endif
    return r;
  endfunction

  task automatic run_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input int stall_idx, input int stall_len,
                           input int idle_wait, input bit mid_start, input bit rand_ready,
                           input bit pre_started, input bit chain_next);
    logic [23:0] exp_q [$];
    int          hs = 0, cyc = 0, post = -1, stall_cnt = 0, last_hs = -10;
    int          stab_err = 0, turn_err = 0, lat_err = 0, lh_cnt = 0, fd_cnt = 0, busy_fall = -1;
    logic        prev_pend = 1'b0;
    logic [23:0] prev_grb = '0;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'(bri_now);
`endif
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1; grb_ready = 1'b1; tx_idle = 1'b0;
      #1;
      chk({tag, " busy at start cycle"}, 64'(busy), 64'(0));
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " busy at t+1"}, 64'(busy), 64'(1));
    chk({tag, " valid low at t+1"}, 64'(grb_valid), 64'(0));
    while (busy_fall < 0 && cyc < 4000 + idle_wait + stall_len) begin
      @(negedge clk);
      if (hs < N) begin
        tx_idle = 1'b0;
        if (hs == stall_idx && stall_cnt < stall_len && grb_valid === 1'b1) begin
          grb_ready = 1'b0;
          stall_cnt++;
        end else if (rand_ready) grb_ready = ($urandom_range(0, 3) != 0);
        else grb_ready = 1'b1;
      end else begin
        post++;
        tx_idle   = (post >= idle_wait);
        grb_ready = ($urandom_range(0, 1) != 0);
      end
      start = (mid_start && cyc == 2) || (chain_next && post == idle_wait + RC);
      #1;
      if (cyc == 0) chk({tag, " valid at t+2"}, 64'(grb_valid), 64'(1));
      if (prev_pend && (grb_valid !== 1'b1 || grb !== prev_grb)) stab_err++;
      prev_pend = grb_valid && !grb_ready;
      prev_grb  = grb;
      if (hs < N) begin
        if (busy !== 1'b1 || line_hold !== 1'b0 || frame_done !== 1'b0) lat_err++;
        if (cyc == last_hs + 1 && grb_valid !== 1'b0) turn_err++;
        if (cyc == last_hs + 2 && grb_valid !== 1'b1) turn_err++;
        if (grb_valid === 1'b1 && grb_ready === 1'b1) begin
          chk($sformatf("%s word%0d", tag, hs), 64'(grb), 64'(exp_q[hs]));
          if (hs == 0) last_word0 = grb;
          hs++;
          last_hs = cyc;
        end
      end else if (post >= 0) begin
        if (line_hold !== (post >= idle_wait && post < idle_wait + RC)) lat_err++;
        if (frame_done !== (post == idle_wait + RC - 1)) lat_err++;
        if (grb_valid !== 1'b0) lat_err++;
        if (line_hold === 1'b1) lh_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (busy === 1'b0) busy_fall = post;
      end
      cyc++;
    end
    chk({tag, " handshakes"}, 64'(hs), 64'(N));
    chk({tag, " stable while stalled"}, 64'(stab_err), 64'(0));
    chk({tag, " turnaround"}, 64'(turn_err), 64'(0));
    chk({tag, " latch phase errors"}, 64'(lat_err), 64'(0));
    chk({tag, " line_hold cycles"}, 64'(lh_cnt), 64'(RC));
    chk({tag, " frame_done pulses"}, 64'(fd_cnt), 64'(1));
    chk({tag, " busy fall cycle"}, 64'(busy_fall), 64'(idle_wait + RC));
    if (!chain_next) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({tag, " idle after frame"}, 64'(busy), 64'(0));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " grb"}, 64'(grb), 64'(0));
    chk({tag, " grb_valid"}, 64'(grb_valid), 64'(0));
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " frame_done"}, 64'(frame_done), 64'(0));
    chk({tag, " line_hold"}, 64'(line_hold), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; grb_ready = 1'b0; tx_idle = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (N) model_mem.push_back('0);

    tbl.push_back('{"basic", 24'h00FF00, 24'h0000FF, 24'hFF0000, 0, 0, 0, 1'b0, 1'b0, 1'b0,
                   24'h00FF00, 24'h0000FF, 24'hFF0000});
    tbl.push_back('{"backpressure", 24'h123456, 24'hABCDEF, 24'h0F0F0F, 1, 100, 0, 1'b0, 1'b0, 1'b0,
                   24'h123456, 24'hABCDEF, 24'h0F0F0F});
    tbl.push_back('{"latch gap", 24'h800000, 24'h000001, 24'h7E7E7E, 0, 0, 500, 1'b0, 1'b0, 1'b1,
                   24'h800000, 24'h000001, 24'h7E7E7E});
    tbl.push_back('{"back-to-back", 24'h800000, 24'h000001, 24'h7E7E7E, 2, 5, 3, 1'b1, 1'b1, 1'b0,
                   24'h800000, 24'h000001, 24'h7E7E7E});

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (!tbl[i].pre_started) begin
        write_px(0, tbl[i].w0);
        write_px(1, tbl[i].w1);
        write_px(2, tbl[i].w2);
        write_px(3 + i, 24'hDEAD00 | 24'(i));
      end
      run_frame(tbl[i].name, tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].stall_idx, tbl[i].stall_len,
                tbl[i].idle_wait, tbl[i].mid_start, 1'b0, tbl[i].pre_started, tbl[i].chain_next);
    end

    // Reset in the middle of the latch gap, then a full replay.
    write_px(0, 24'hA5A5A5);
    write_px(1, 24'h5A5A5A);
    write_px(2, 24'h010203);
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1; grb_ready = 1'b1; tx_idle = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        #1;
        if (line_hold === 1'b1) seen = 1'b1;
      end
      chk("latch reached before reset", 64'(seen), 64'(1));
      repeat (20) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("mid-latch reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("idle after reset release", 64'(busy), 64'(0));
    end
    write_px(0, 24'hA5A5A5);
    write_px(1, 24'h5A5A5A);
    write_px(2, 24'h010203);
    run_frame("replay after reset", 24'hA5A5A5, 24'h5A5A5A, 24'h010203, 0, 0, 2,
              1'b0, 1'b0, 1'b0, 1'b0);

`ifdef WS2812_BRIGHTNESS_EN
    bri_now = 127;
    write_px(0, 24'hFF8040);
    run_frame("brightness 127", exp_word(0), exp_word(1), exp_word(2), 0, 0, 0,
              1'b0, 1'b0, 1'b0, 1'b0);
    chk("brightness 127 word0", 64'(last_word0), 64'(24'h7F4020));
    bri_now = 255;
    run_frame("brightness 255", exp_word(0), exp_word(1), exp_word(2), 0, 0, 0,
              1'b0, 1'b0, 1'b0, 1'b0);
    chk("brightness 255 word0", 64'(last_word0), 64'(24'hFF8040));
`endif

    for (int r = 0; r < 5; r++) begin
      bit pre;
      pre = (r == 3);
`ifdef WS2812_BRIGHTNESS_EN
      if (!pre) bri_now = int'($urandom_range(0, 255));
`endif
      if (!pre) begin
        for (int a = 0; a < N; a++) write_px(a, 24'($urandom));
        write_px(int'($urandom_range(N, (1 << AW) - 1)), 24'($urandom));
      end
      run_frame($sformatf("random%0d", r), exp_word(0), exp_word(1), exp_word(2),
                int'($urandom_range(0, N - 1)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 30)), ($urandom_range(0, 1) != 0), 1'b1, pre, (r == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
